// File: rtl/plot_arbiter.sv
// Round-robin arbiter that shares the single VGA plot port among N drawing engines.
// One engine at a time is granted, started, and has its pixel stream muxed out until done or watchdog expiry.
module plot_arbiter #(
    parameter int N       = 4,
    parameter int OWNER_W = $clog2(N),
    parameter int TIMEOUT = 2047,
    parameter int CNT_W   = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       done,
    input  logic [8*N-1:0]     x_in,
    input  logic [7*N-1:0]     y_in,
    input  logic [3*N-1:0]     c_in,
    output logic [N-1:0]       start,
    output logic [7:0]         x_out,
    output logic [6:0]         y_out,
    output logic [2:0]         c_out,
    output logic               plot,
    output logic               busy,
    output logic [OWNER_W-1:0] owner,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAW,
        RELEASE
    } state_t;

    localparam logic [OWNER_W-1:0] LAST_ENGINE = OWNER_W'(N - 1);
    localparam logic [CNT_W-1:0]   WDOG_LIMIT  = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;
    logic               err_q, err_d;

    logic [OWNER_W-1:0] winner;
    logic [OWNER_W-1:0] scan_idx;
    logic               found;
    logic               owner_done;
    logic [7:0]         x_sel;
    logic [6:0]         y_sel;
    logic [2:0]         c_sel;

    // Scan starting just after the last owner so the most recent winner has lowest priority.
    always_comb begin
        winner   = owner_q;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = OWNER_W'((int'(owner_q) + k) % N);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        c_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == OWNER_W'(i)) begin
                x_sel = x_in[8*i +: 8];
                y_sel = y_in[7*i +: 7];
                c_sel = c_in[3*i +: 3];
            end
        end
    end

    assign owner_done = done[owner_q];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wdog_d  = '0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = DRAW;
            end
            DRAW: begin
                wdog_d = wdog_q + CNT_W'(1);
                // A done arriving on the final watchdog cycle counts as a clean finish.
                if (owner_done) begin
                    state_d = RELEASE;
                end else if (wdog_q == WDOG_LIMIT) begin
                    state_d = RELEASE;
                    err_d   = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= LAST_ENGINE;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced quiet while reset is held, even before the state register clears.
    always_comb begin
        start = '0;
        plot  = 1'b0;
        x_out = '0;
        y_out = '0;
        c_out = '0;
        busy  = 1'b0;
        if (!reset) begin
            busy = (state_q != IDLE);
            case (state_q)
                GRANT: begin
                    start[owner_q] = 1'b1;
                end
                DRAW: begin
                    plot  = 1'b1;
                    x_out = x_sel;
                    y_out = y_sel;
                    c_out = c_sel;
                end
                default: begin
                    plot = 1'b0;
                end
            endcase
        end
    end

    assign owner       = owner_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter: a default instance plus a short-watchdog instance.
module tb_plot_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  done = '0;
    logic [31:0] x_in = {8'h44, 8'h33, 8'h22, 8'h11};
    logic [27:0] y_in = {7'h34, 7'h23, 7'h12, 7'h01};
    logic [11:0] c_in = {3'd4, 3'd3, 3'd2, 3'd1};

    logic [3:0]  start, start_w;
    logic [7:0]  x_out, x_out_w;
    logic [6:0]  y_out, y_out_w;
    logic [2:0]  c_out, c_out_w;
    logic        plot, plot_w, busy, busy_w, terr, terr_w;
    logic [1:0]  owner, owner_w;

    int n_assert = 0;
    int n_fail   = 0;

    plot_arbiter #(.N(4), .TIMEOUT(2047), .CNT_W(11)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .c_in(c_in),
        .start(start), .x_out(x_out), .y_out(y_out), .c_out(c_out),
        .plot(plot), .busy(busy), .owner(owner), .timeout_err(terr)
    );

    plot_arbiter #(.N(4), .TIMEOUT(16), .CNT_W(5)) dut_wd (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .c_in(c_in),
        .start(start_w), .x_out(x_out_w), .y_out(y_out_w), .c_out(c_out_w),
        .plot(plot_w), .busy(busy_w), .owner(owner_w), .timeout_err(terr_w)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        done  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Runs one complete grant on either instance; who is -1 if no start pulse appears.
    task automatic run_grant(input logic [3:0] r, input bit use_wd, output int who);
        logic [3:0] s;
        who = -1;
        req = r;
        for (int t = 0; t < 20 && who < 0; t++) begin
            tick();
            s = use_wd ? start_w : start;
            for (int i = 0; i < 4; i++) if (s[i]) who = i;
        end
        req = '0;
        if (who >= 0) begin
            tick();
            tick();
            done = 4'b0001 << who;
            tick();
            done = '0;
            tick();
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        tick();
        n_assert++;
        if (start !== 4'b0 || plot !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: start=%b plot=%b busy=%b, required 0000/0/0", start, plot, busy);
        end
        n_assert++;
        if (x_out !== 8'h0 || y_out !== 7'h0 || c_out !== 3'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: x=%h y=%h c=%h, required 0/0/0", x_out, y_out, c_out);
        end
        n_assert++;
        if (owner !== 2'd3 || terr !== 1'b0 || terr_w !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_owner: owner=%0d terr=%b terr_w=%b, required 3/0/0", owner, terr, terr_w);
        end
        req   = '0;
        reset = 1'b0;
        tick();
        n_assert++;
        if (busy !== 1'b0 || owner !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL idle_hold: busy=%b owner=%0d, required 0/3", busy, owner);
        end
    endtask

    task automatic test_single;
        int         bad;
        logic [7:0] xv;
        do_reset();
        req = 4'b0100;
        tick();
        n_assert++;
        if (start !== 4'b0100 || busy !== 1'b1 || plot !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_start: start=%b busy=%b plot=%b, required 0100/1/0", start, busy, plot);
        end
        bad = 0;
        for (int i = 1; i <= 920; i++) begin
            tick();
            xv = 8'(i) ^ 8'h5A;
            x_in[23:16] = xv;
            #1;
            if (plot !== 1'b1 || start !== 4'b0 || x_out !== xv || y_out !== 7'h23 ||
                c_out !== 3'd3 || owner !== 2'd2) bad++;
            if (i == 2) req = '0;
            if (i == 920) done = 4'b0100;
        end
        n_assert++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL single_draw: %0d bad draw cycles, required 0", bad);
        end
        tick();
        done = '0;
        n_assert++;
        if (plot !== 1'b0 || busy !== 1'b1 || x_out !== 8'h0) begin
            n_fail++;
            $display("[TB] FAIL single_release: plot=%b busy=%b x=%h, required 0/1/00", plot, busy, x_out);
        end
        tick();
        n_assert++;
        if (busy !== 1'b0 || owner !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL single_idle: busy=%b owner=%0d, required 0/2", busy, owner);
        end
    endtask

    task automatic test_round_robin;
        int         order[5];
        int         times[5];
        int         got;
        int         due;
        logic [3:0] pend;
        for (int i = 0; i < 5; i++) begin
            order[i] = -1;
            times[i] = 0;
        end
        got  = 0;
        due  = -1;
        pend = '0;
        do_reset();
        req = 4'b1111;
        for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
            tick();
            done = '0;
            if (start != 4'b0) begin
                for (int i = 0; i < 4; i++) if (start[i]) order[got] = i;
                times[got] = cyc;
                got++;
                pend = start;
                due  = cyc + 10;
            end
            if (cyc == due) done = pend;
        end
        req  = '0;
        done = '0;
        n_assert++;
        if (got !== 5) begin
            n_fail++;
            $display("[TB] FAIL rr_count: %0d grants seen, required 5", got);
        end
        for (int i = 0; i < 5; i++) begin
            n_assert++;
            if (order[i] !== i % 4) begin
                n_fail++;
                $display("[TB] FAIL rr_order[%0d]: got engine %0d, required %0d", i, order[i], i % 4);
            end
        end
        for (int i = 1; i < 5; i++) begin
            n_assert++;
            if (times[i] - times[i-1] !== 13) begin
                n_fail++;
                $display("[TB] FAIL rr_gap[%0d]: %0d cycles, required 13", i, times[i] - times[i-1]);
            end
        end
    endtask

    task automatic test_skip_idle;
        int w;
        do_reset();
        run_grant(4'b0010, 1'b0, w);
        n_assert++;
        if (w !== 1) begin
            n_fail++;
            $display("[TB] FAIL skip_first: engine %0d, required 1", w);
        end
        run_grant(4'b0001, 1'b0, w);
        n_assert++;
        if (w !== 0) begin
            n_fail++;
            $display("[TB] FAIL skip_wrap: engine %0d, required 0", w);
        end
        run_grant(4'b1001, 1'b0, w);
        n_assert++;
        if (w !== 3 || owner !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL skip_to_3: engine %0d owner %0d, required 3/3", w, owner);
        end
    endtask

    task automatic test_watchdog;
        int hi;
        int w;
        bit seen;
        do_reset();
        req  = 4'b0010;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (start_w != 4'b0) seen = 1'b1;
        end
        req = '0;
        n_assert++;
        if (start_w !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL wd_start: start=%b, required 0010", start_w);
        end
        hi = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (plot_w) hi++;
            else if (hi > 0) break;
        end
        n_assert++;
        if (hi !== 16) begin
            n_fail++;
            $display("[TB] FAIL wd_plot_len: %0d plot cycles, required 16", hi);
        end
        n_assert++;
        if (busy_w !== 1'b1 || terr_w !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wd_release: busy=%b terr=%b, required 1/1", busy_w, terr_w);
        end
        tick();
        n_assert++;
        if (busy_w !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wd_idle: busy=%b, required 0", busy_w);
        end
        run_grant(4'b0100, 1'b1, w);
        n_assert++;
        if (w !== 2 || terr_w !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wd_sticky: engine %0d terr=%b, required 2/1", w, terr_w);
        end
        do_reset();
        n_assert++;
        if (terr_w !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wd_clear: terr=%b, required 0", terr_w);
        end
    endtask

    task automatic test_stray_done;
        int bad;
        bit seen;
        do_reset();
        req  = 4'b0001;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (start_w != 4'b0) seen = 1'b1;
        end
        req  = '0;
        done = 4'b0001;
        n_assert++;
        if (start_w !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL stray_start: start=%b, required 0001", start_w);
        end
        bad = 0;
        for (int j = 1; j <= 17; j++) begin
            tick();
            done = '0;
            if (j <= 16 && (plot_w !== 1'b1 || owner_w !== 2'd0)) bad++;
            if (j == 17) begin
                n_assert++;
                if (plot_w !== 1'b0 || busy_w !== 1'b1 || terr_w !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL simul_done: plot=%b busy=%b terr=%b, required 0/1/0",
                             plot_w, busy_w, terr_w);
                end
            end
            if (j == 4) done = 4'b1000;
            if (j == 16) done = 4'b0001;
        end
        n_assert++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL stray_ignored: %0d bad draw cycles, required 0", bad);
        end
        tick();
        n_assert++;
        if (busy_w !== 1'b0 || terr_w !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL simul_idle: busy=%b terr=%b, required 0/0", busy_w, terr_w);
        end
    endtask

    task automatic test_reset_mid_draw;
        bit seen;
        do_reset();
        req  = 4'b0010;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (start != 4'b0) seen = 1'b1;
        end
        req = '0;
        for (int j = 1; j <= 50; j++) tick();
        n_assert++;
        if (plot !== 1'b1 || owner !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL mid_draw_pre: plot=%b owner=%0d, required 1/1", plot, owner);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_assert++;
        if (plot !== 1'b0 || start !== 4'b0 || busy !== 1'b0 || owner !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL mid_draw_reset: plot=%b start=%b busy=%b owner=%0d, required 0/0000/0/3",
                     plot, start, busy, owner);
        end
        req  = 4'b1111;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (start != 4'b0) seen = 1'b1;
        end
        req = '0;
        n_assert++;
        if (start !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL mid_draw_regrant: start=%b, required 0001", start);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skip_idle();
        test_watchdog();
        test_stray_done();
        test_reset_mid_draw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA plot port (x/y/colour/plot) among N drawing engines: beam, ship, asteroids, score.
- Each engine raises a request. The arbiter picks one round-robin and pulses that engine's start. It then muxes the engine's pixel stream to the VGA adapter until the engine's done pulse arrives or a watchdog expires.
- Sits between the game FSM's engine instances and the VGA adapter.

Parameters:
- N, 4, number of requesting engines (2..8).
- OWNER_W, $clog2(N), width of owner index.
- TIMEOUT, 2047, max DRAW cycles before forced release. Must exceed the longest engine draw (beam = 920 cycles).
- CNT_W, 11, watchdog counter width; 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-engine draw request, level; bit i = engine i.
- done  in  N  per-engine one-cycle completion pulse.
- x_in  in  8*N  engine x coords, engine i at [8i+7:8i].
- y_in  in  7*N  engine y coords, engine i at [7i+6:7i].
- c_in  in  3*N  engine colours, engine i at [3i+2:3i].
- start  out  N  one-hot, one-cycle start pulse to the granted engine.
- x_out  out  8  x to VGA adapter.
- y_out  out  7  y to VGA adapter.
- c_out  out  3  colour to VGA adapter.
- plot  out  1  VGA write enable.
- busy  out  1  high in any state except IDLE.
- owner  out  OWNER_W  index of the current/last granted engine.
- timeout_err  out  1  sticky flag, set on watchdog expiry.

Behaviour:
- Registered state machine with states IDLE, GRANT, DRAW, RELEASE. Outputs are combinational decode of the registered state and owner.
- Reset (sync, active-high, priority over everything):
  - state=IDLE, owner=N-1 (so engine 0 wins first), watchdog=0, timeout_err=0.
  - Outputs during reset: start=0, plot=0, busy=0, x_out=0, y_out=0, c_out=0.
- IDLE:
  - If req!=0, select the winner and register owner at the clock edge; next state GRANT.
  - Winner = first set bit of req scanning (owner+1) mod N, (owner+2) mod N, ..., wrapping.
  - If req==0, stay in IDLE and hold owner.
- GRANT: exactly one cycle. start[owner]=1, all other start bits 0. Next state DRAW.
- DRAW:
  - plot=1; x_out/y_out/c_out = slices [owner] of x_in/y_in/c_in, combinational passthrough with zero latency.
  - Watchdog increments each DRAW cycle, starting from 0 on entry.
  - If done[owner]=1, next state RELEASE.
  - Else if watchdog==TIMEOUT-1, next state RELEASE and set timeout_err (sticky until reset).
  - done and timeout in the same cycle: go to RELEASE with timeout_err NOT set (done wins).
- RELEASE: exactly one cycle; plot=0, watchdog cleared. Next state IDLE. Gives the engine a cycle to drop req.
- Outside DRAW: plot=0 and x_out=y_out=c_out=0.
- Latency:
  - req sampled high in IDLE at cycle k: start pulse in cycle k+1, plot high from cycle k+2.
  - done[owner] in cycle m: plot low in cycle m+1, IDLE in cycle m+2, earliest next start in cycle m+3.
- Ignored inputs:
  - done bits from non-owners in any state.
  - done[owner] in GRANT, RELEASE or IDLE.
  - Changes to req while busy; the owner keeps the port even if its req drops.
- Fairness: with all req bits held high, grants go 0,1,2,...,N-1,0,... Under continuous contention no engine waits more than N-1 other grants.
- Reset mid-DRAW: returns to IDLE next cycle with plot=0. Engines must be reset by the same signal; no done is awaited.

Test Plan:
- Single requester: reset, req=4'b0100 from cycle 3; engine model asserts done[2] 920 cycles after its start. Required: start=4'b0100 in cycle 4 only; plot=1 cycles 5..924 with x_out=x_in[23:16]; plot=0 from cycle 925; busy=0 from cycle 926; owner=2.
- Round-robin: req=4'b1111 held; each engine pulses done 10 cycles after its start. Required: grant order 0,1,2,3,0; exactly 13 cycles between consecutive start pulses.
- Skip idle requesters: owner=1, req=4'b0001. Required: next grant to engine 0 (wrap). Then with req=4'b1001, required: next grant to 3.
- Watchdog: TIMEOUT=16, engine 1 never pulses done. Required: plot high exactly 16 cycles, then RELEASE; timeout_err=1 and stays 1 through later normal grants until reset.
- Stray and simultaneous done: during engine 0's DRAW, pulse done[3] (required: no effect). Pulse done[0] in the same cycle the watchdog hits TIMEOUT-1 (required: RELEASE, timeout_err stays 0).
- Reset mid-DRAW: assert reset in DRAW cycle 50. Required: next cycle state IDLE, plot=0, start=0, owner=N-1; a subsequent req=4'b1111 grants engine 0 first.
